// File: rtl/channel_init_sched_if.sv
// channel_init_sched_if: request/interrupt/status bundle for the channel init scheduler (abort port under CHINIT_ABORT_EN)
interface channel_init_sched_if #(
  parameter int NCH = 8,
  parameter int CW  = 3
);
  logic           req_wr;
  logic [NCH-1:0] req_mask;
  logic [NCH-1:0] intr_pulse;
  logic           err_clr;
`ifdef CHINIT_ABORT_EN
  logic           abort;
`endif
  logic [NCH-1:0] doinit_pulse;
  logic [NCH-1:0] pending;
  logic           busy;
  logic [CW-1:0]  cur_ch;
  logic           done_pulse;
  logic           timeout_err;
  logic [CW-1:0]  timeout_ch;
`ifdef CHINIT_ABORT_EN
  modport master (output req_wr, req_mask, intr_pulse, err_clr, abort,
                  input doinit_pulse, pending, busy, cur_ch, done_pulse, timeout_err, timeout_ch);
  modport slave  (input req_wr, req_mask, intr_pulse, err_clr, abort,
                  output doinit_pulse, pending, busy, cur_ch, done_pulse, timeout_err, timeout_ch);
`else
  modport master (output req_wr, req_mask, intr_pulse, err_clr,
                  input doinit_pulse, pending, busy, cur_ch, done_pulse, timeout_err, timeout_ch);
  modport slave  (input req_wr, req_mask, intr_pulse, err_clr,
                  output doinit_pulse, pending, busy, cur_ch, done_pulse, timeout_err, timeout_ch);
`endif
endinterface

// File: rtl/channel_init_sched.sv
// channel_init_sched: round-robin one-at-a-time do_init sequencer with watchdog; optional abort via CHINIT_ABORT_EN
module channel_init_sched #(
  parameter int NCH     = 8,
  parameter int CW      = 3,
  parameter int TIMEOUT = 65535
) (
  input logic clk,
  input logic reset,
  channel_init_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t         state_q, state_d;
  logic [NCH-1:0] pending_q, pending_d, clr_mask;
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d, cur_ch_q, cur_ch_d, timeout_ch_q, timeout_ch_d, sel_ch, nxt_ch;
  logic [19:0]    wdog_q, wdog_d;
  logic           timeout_err_q, timeout_err_d, done, tmo_set, hit, tmo;
  int             j;
  // descending scan so the lowest offset from rr_ptr is the one left standing
  always_comb begin
    sel_ch = '0;
    j = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = int'(rr_ptr_q) + i;
      j = (j >= NCH) ? j - NCH : j;
      if (pending_q[j]) sel_ch = CW'(j);
    end
  end
  assign hit    = bus.intr_pulse[cur_ch_q];
  assign tmo    = wdog_q == 20'(TIMEOUT - 1);
  assign nxt_ch = (cur_ch_q == CW'(NCH - 1)) ? '0 : cur_ch_q + CW'(1);
  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    rr_ptr_d     = rr_ptr_q;
    wdog_d       = wdog_q;
    timeout_ch_d = timeout_ch_q;
    clr_mask     = '0;
    done         = 1'b0;
    tmo_set      = 1'b0;
    case (state_q)
      IDLE: begin
        cur_ch_d = (|pending_q) ? sel_ch : cur_ch_q;
        state_d  = (|pending_q) ? ISSUE : IDLE;
      end
      ISSUE: begin
        clr_mask = NCH'(1) << cur_ch_q;
        wdog_d   = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        wdog_d       = wdog_q + 20'd1;
        done         = hit;
        tmo_set      = !hit && tmo;
        timeout_ch_d = tmo_set ? cur_ch_q : timeout_ch_q;
        rr_ptr_d     = (hit || tmo) ? nxt_ch : rr_ptr_q;
        state_d      = (hit || tmo) ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~clr_mask) | (bus.req_wr ? bus.req_mask : '0);
`ifdef CHINIT_ABORT_EN
    if (bus.abort) begin
      pending_d    = '0;
      state_d      = IDLE;
      done         = 1'b0;
      tmo_set      = 1'b0;
      rr_ptr_d     = rr_ptr_q;
      timeout_ch_d = timeout_ch_q;
    end
`endif
    timeout_err_d = tmo_set | (timeout_err_q & ~bus.err_clr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      cur_ch_q      <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      timeout_ch_q  <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_ch_q      <= cur_ch_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      timeout_ch_q  <= timeout_ch_d;
    end
  end
  assign bus.doinit_pulse = clr_mask;
  assign bus.pending      = pending_q;
  assign bus.busy         = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.cur_ch       = cur_ch_q;
  assign bus.done_pulse   = done;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.timeout_ch   = timeout_ch_q;
endmodule

// File: tb/tb_channel_init_sched.sv
// tb_channel_init_sched: directed stimulus with expected doinit/done/timeout events queued for a negedge monitor
module tb_channel_init_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string       name;
    logic [25:0] v;
  } exp_t;
  exp_t q[$];
  logic prev_tmo = 1'b0;
  logic tmo_rise;
  channel_init_sched_if #(.NCH(8), .CW(3)) bus ();
  channel_init_sched #(.NCH(8), .CW(3), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic goto(input int c);
    while (cyc < c) step();
  endtask
  task automatic push(input string n, input logic [7:0] d, input logic dn, input logic t, input int c);
    exp_t e;
    e.name = n;
    e.v = {d, dn, t, 16'(c)};
    q.push_back(e);
  endtask
  task automatic req(input logic [7:0] m);
    bus.req_wr = 1'b1;
    bus.req_mask = m;
    step();
    bus.req_wr = 1'b0;
    bus.req_mask = '0;
  endtask
  task automatic intr(input logic [7:0] m);
    bus.intr_pulse = m;
    step();
    bus.intr_pulse = '0;
  endtask
  task automatic serve(input string n, input int ch, input int iss, input int d);
    push(n, 8'(1 << ch), 1'b0, 1'b0, iss);
    goto(iss + d);
    push({n, "_done"}, 8'h00, 1'b1, 1'b0, iss + d);
    intr(8'(1 << ch));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  always @(negedge clk) begin
    tmo_rise = bus.timeout_err && !prev_tmo;
    prev_tmo = bus.timeout_err;
    if (bus.doinit_pulse != 8'h00 || bus.done_pulse || tmo_rise) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got doinit=%0h done=%0b tmo=%0b want none (cycle %0d)",
                 bus.doinit_pulse, bus.done_pulse, tmo_rise, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(e.name, {6'd0, bus.doinit_pulse, bus.done_pulse, tmo_rise, 16'(cyc)}, {6'd0, e.v});
      end
    end
  end
  initial begin
    int c;
    bus.req_wr = 1'b0;
    bus.req_mask = '0;
    bus.intr_pulse = '0;
    bus.err_clr = 1'b0;
`ifdef CHINIT_ABORT_EN
    bus.abort = 1'b0;
`endif
    do_reset();
    chk("rst_pending", bus.pending, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cur_ch", bus.cur_ch, 0);
    chk("rst_terr", bus.timeout_err, 0);
    chk("rst_doinit", bus.doinit_pulse, 0);
    // single channel: 2-cycle issue latency, done at intr cycle
    c = cyc;
    req(8'h01);
    goto(c + 2);
    chk("t1_busy_hi", bus.busy, 1);
    serve("t1_ch0", 0, c + 2, 8);
    chk("t1_busy_lo", bus.busy, 0);
    chk("t1_pending", bus.pending, 0);
    // round robin 0,2,7 then wrap to 0,2
    do_reset();
    c = cyc;
    req(8'h85);
    serve("t2_ch0", 0, c + 2, 5);
    serve("t2_ch2", 2, c + 9, 5);
    serve("t2_ch7", 7, c + 16, 5);
    c = cyc;
    req(8'h05);
    serve("t2_wrap_ch0", 0, c + 2, 5);
    serve("t2_wrap_ch2", 2, c + 9, 5);
    // watchdog timeout on ch3
    do_reset();
    c = cyc;
    push("t3_issue", 8'h08, 1'b0, 1'b0, c + 2);
    req(8'h08);
    goto(c + 18);
    chk("t3_busy_before", bus.busy, 1);
    chk("t3_terr_before", bus.timeout_err, 0);
    push("t3_tmo", 8'h00, 1'b0, 1'b1, c + 19);
    step();
    chk("t3_terr", bus.timeout_err, 1);
    chk("t3_tch", bus.timeout_ch, 3);
    chk("t3_busy_after", bus.busy, 0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("t3_terr_clr", bus.timeout_err, 0);
    chk("t3_tch_kept", bus.timeout_ch, 3);
    // filtering of early and foreign intr pulses
    c = cyc;
    push("t4_issue", 8'h02, 1'b0, 1'b0, c + 2);
    req(8'h02);
    goto(c + 2);
    bus.intr_pulse = 8'h02;
    step();
    bus.intr_pulse = 8'h04;
    step();
    bus.intr_pulse = 8'h00;
    chk("t4_busy_still", bus.busy, 1);
    goto(c + 8);
    push("t4_done", 8'h00, 1'b1, 1'b0, c + 8);
    intr(8'h02);
    chk("t4_busy_lo", bus.busy, 0);
    // re-request during ISSUE, then intr coincident with timeout
    c = cyc;
    push("t5_issue", 8'h02, 1'b0, 1'b0, c + 2);
    req(8'h02);
    goto(c + 2);
    req(8'h02);
    chk("t5_pending_kept", bus.pending, 8'h02);
    goto(c + 5);
    push("t5_done", 8'h00, 1'b1, 1'b0, c + 5);
    intr(8'h02);
    serve("t5_reissue", 1, c + 7, 16);
    chk("t5_terr_stays0", bus.timeout_err, 0);
    chk("t5_busy_lo", bus.busy, 0);
    // reset mid-WAIT with pending work
    c = cyc;
    push("t6_issue", 8'h01, 1'b0, 1'b0, c + 2);
    req(8'h01);
    goto(c + 3);
    req(8'hF0);
    chk("t6_pending_f0", bus.pending, 8'hF0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_pending", bus.pending, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_cur_ch", bus.cur_ch, 0);
    chk("t6_tch", bus.timeout_ch, 0);
    goto(c + 20);
    chk("t6_idle", bus.busy, 0);
`ifdef CHINIT_ABORT_EN
    c = cyc;
    push("t7_issue", 8'h01, 1'b0, 1'b0, c + 2);
    req(8'h01);
    goto(c + 3);
    req(8'hF0);
    bus.abort = 1'b1;
    bus.intr_pulse = 8'h01;
    step();
    bus.abort = 1'b0;
    bus.intr_pulse = 8'h00;
    chk("t7_pending", bus.pending, 0);
    chk("t7_busy", bus.busy, 0);
    goto(c + 15);
    chk("t7_idle", bus.busy, 0);
`endif
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/channel_init_sched.md
Name: channel_init_sched

Overview:
- Sequences do_init requests across the NCH correlator channels of the imitator, so only one channel is initialising at any time.
- Software writes a mask of channels to initialise. The block round-robins through the pending set and fires a one-cycle doinit_pulse to one channel.
- It then waits for that channel's intr_pulse, the epoch event that clears the channel's doinit flag, before serving the next channel.
- A watchdog timeout prevents a dead channel from stalling the queue.

Parameters:
- NCH, 8, number of correlator channels served (2..32).
- CW, 3, width of the channel index; must equal ceil(log2(NCH)).
- TIMEOUT, 65535, clk cycles to wait for intr_pulse before abandoning a channel (1..2^20-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_wr  in  1  one-cycle strobe; req_mask is OR-ed into pending.
- req_mask  in  NCH  channels to initialise.
- intr_pulse  in  NCH  per-channel epoch/interrupt pulse.
- err_clr  in  1  clears timeout_err.
- doinit_pulse  out  NCH  one-hot, one-cycle init strobe to a channel.
- pending  out  NCH  channels queued but not yet issued.
- busy  out  1  high in ISSUE or WAIT.
- cur_ch  out  CW  channel in ISSUE/WAIT; holds the last value when idle.
- done_pulse  out  1  one cycle when the current channel's intr_pulse is received.
- timeout_err  out  1  sticky; set when a channel times out.
- timeout_ch  out  CW  channel that most recently timed out.

Behaviour:
- Reset values (the same values apply when reset is asserted mid-operation; any in-flight init is dropped silently):
  - all outputs 0; pending=0; rr_ptr=0; FSM=IDLE; wdog=0.
- pending update, every cycle:
  - pending_next = (pending & ~clr_mask) | (req_wr ? req_mask : 0).
  - On a simultaneous request and clear of the same bit, the set wins.
- FSM state IDLE:
  - If pending!=0, select the first set bit scanning rr_ptr, rr_ptr+1, … with wrap modulo NCH.
  - Register it into cur_ch and go to ISSUE.
  - Pending bits set in the same cycle are not visible until the next cycle.
- FSM state ISSUE (1 cycle):
  - doinit_pulse[cur_ch]=1; clr_mask bit cur_ch=1; wdog=0; go to WAIT.
  - Latency from the req_wr cycle to doinit_pulse, with the block idle: 2 cycles.
- FSM state WAIT:
  - wdog increments each cycle.
  - If intr_pulse[cur_ch]=1: done_pulse=1; rr_ptr=(cur_ch+1) mod NCH; go to IDLE.
  - Else if wdog==TIMEOUT-1: timeout_err=1; timeout_ch=cur_ch; rr_ptr=(cur_ch+1) mod NCH; go to IDLE; done_pulse is not asserted.
  - If intr_pulse and timeout occur in the same cycle, intr_pulse wins.
- Ignored inputs:
  - intr_pulse on non-current channels, in any state.
  - intr_pulse[cur_ch] during the ISSUE cycle; a pulse that early would precede the channel's doinit assertion.
- Back-to-back throughput: a WAIT exit to IDLE, IDLE select, then ISSUE, so the minimum spacing between doinit_pulses is 3 cycles plus the wait time.
- A channel re-requested while it is in WAIT is queued again and served on its next round-robin turn.
- err_clr clears timeout_err. If a timeout occurs in the same cycle, the set wins. timeout_ch is not cleared.
- busy = (state==ISSUE) | (state==WAIT).
- doinit_pulse is at most one-hot.
- Parameters are not range-checked at run time.

Optional Feature:
- Macro: CHINIT_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit), placed after err_clr.
  - abort=1 in any cycle forces pending=0 (abort beats req_wr in that cycle) and FSM=IDLE on the next edge.
  - abort suppresses done_pulse and timeout_err for that cycle; rr_ptr is unchanged.
  - A doinit already delivered to a channel is not recalled.
- Not defined: the port is absent and the behaviour above applies unchanged.

Test Plan:
1. NCH=8, reset, then req_wr with mask 0x01 at cycle 0 -> doinit_pulse=0x01 at cycle 2, busy high from cycle 2. intr_pulse[0] at cycle 10 -> done_pulse at cycle 10, busy low at cycle 11, pending=0.
2. Round-robin: req_mask=0x85 written once; answer each intr_pulse after 5 cycles -> doinit order ch0, ch2, ch7. Then write 0x05 -> order ch0, ch2 (rr_ptr wraps to 0 after ch7).
3. Timeout: TIMEOUT=16, req_mask=0x08, no intr_pulse -> 16 cycles after ISSUE: timeout_err=1, timeout_ch=3, no done_pulse. err_clr then clears timeout_err to 0.
4. Filtering: ch1 in WAIT; intr_pulse=0x04 and intr_pulse[1] during ISSUE -> ignored, still busy. intr_pulse=0x02 later -> done_pulse.
5. Collisions:
   - req_wr 0x02 during ch1's ISSUE cycle -> pending[1] stays 1 and ch1 is reissued next.
   - intr_pulse[cur] coincident with timeout expiry -> done_pulse=1, timeout_err stays 0.
6. Reset mid-WAIT with pending=0xF0 -> all outputs 0 next cycle; no doinit_pulse until a new req_wr. With CHINIT_ABORT_EN: abort mid-WAIT -> IDLE, pending=0, no done_pulse.
